// File: rtl/i2c_apb_pkg.sv
// Shared constants for the I2C APB register block: register map, STATUS/IRQ_EN/CMD bit positions.
// The top-level decode and the command outputs both index registers through these names.
package i2c_apb_pkg;

    localparam logic [7:0] ADDR_PRESCALE   = 8'h00;
    localparam logic [7:0] ADDR_CMD        = 8'h01;
    localparam logic [7:0] ADDR_SLAVE_ADDR = 8'h02;
    localparam logic [7:0] ADDR_TX_DATA    = 8'h03;
    localparam logic [7:0] ADDR_RX_DATA    = 8'h04;
    localparam logic [7:0] ADDR_STATUS     = 8'h05;
    localparam logic [7:0] ADDR_IRQ_EN     = 8'h06;

    localparam logic [7:0] PRESCALE_RESET  = 8'h04;

    localparam int STAT_TX_EMPTY = 0;
    localparam int STAT_TX_FULL  = 1;
    localparam int STAT_RX_EMPTY = 2;
    localparam int STAT_RX_FULL  = 3;
    localparam int STAT_TX_OVF   = 4;
    localparam int STAT_RX_OVF   = 5;
    localparam int STAT_RX_UNDER = 6;
    localparam int STAT_TX_UNDER = 7;

    localparam int IRQ_RX_NOT_EMPTY = 0;
    localparam int IRQ_TX_EMPTY     = 1;
    localparam int IRQ_ERR          = 2;

    localparam int CMD_RESET_N      = 7;
    localparam int CMD_ENABLE       = 6;
    localparam int CMD_REPEAT_START = 5;
    localparam int CMD_RW           = 4;

    // Only the defined CMD bits are storable; bits 3:0 always read back 0.
    localparam logic [7:0] CMD_WRITE_MASK = (8'h1 << CMD_RESET_N) | (8'h1 << CMD_ENABLE)
                                          | (8'h1 << CMD_REPEAT_START) | (8'h1 << CMD_RW);

    // Sticky error bits, MSB first so the struct maps directly onto STATUS[7:4].
    typedef struct packed {
        logic tx_under;
        logic rx_under;
        logic rx_ovf;
        logic tx_ovf;
    } sticky_t;

endpackage

// File: rtl/i2c_sync_fifo.sv
// Single-clock FIFO with first-word fall-through head and extra-MSB pointers for full/empty.
// Flush holds both pointers at zero; overflow/underflow are single-cycle pulses for rejected requests.
module i2c_sync_fifo #(
    parameter int DATA_SIZE  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push_i,
    input  logic                 pop_i,
    input  logic                 flush_i,
    input  logic [DATA_SIZE-1:0] wdata_i,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [DATA_SIZE-1:0] head_o,
    output logic                 overflow_o,
    output logic                 underflow_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]        wptr_q, wptr_d;
    logic [PW-1:0]        rptr_q, rptr_d;
    logic [DATA_SIZE-1:0] mem_q [FIFO_DEPTH];
    logic                 push_ok;
    logic                 pop_ok;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[PW-1] != rptr_q[PW-1]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    // Full/empty are judged on the current pointers, so a push on a full FIFO is lost even if a pop lands too.
    assign push_ok     = push_i & ~full_o & ~flush_i;
    assign pop_ok      = pop_i & ~empty_o & ~flush_i;
    assign overflow_o  = push_i & full_o & ~flush_i;
    assign underflow_o = pop_i & empty_o & ~flush_i;

    assign head_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (push_ok) wptr_d = wptr_q + PW'(1);
            if (pop_ok)  rptr_d = rptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/i2c_apb_regs.sv
// APB register block feeding the I2C master core: CMD/PRESCALE/SLAVE_ADDR registers,
// TX FIFO drained by the core, RX FIFO filled by the core, sticky errors and a registered interrupt.
module i2c_apb_regs
    import i2c_apb_pkg::*;
#(
    parameter int DATA_SIZE  = 8,
    parameter int ADDR_SIZE  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 APB_clk_i,
    input  logic                 reset_ni,
    input  logic                 psel_i,
    input  logic                 penable_i,
    input  logic                 pwrite_i,
    input  logic [7:0]           paddr_i,
    input  logic [7:0]           pwdata_i,
    output logic [7:0]           prdata_o,
    output logic                 pready_o,
    output logic                 pslverr_o,
    input  logic                 r_fifo_en_i,
    output logic [DATA_SIZE-1:0] data_o,
    input  logic                 w_fifo_en_i,
    input  logic [DATA_SIZE-1:0] data_from_sda_i,
    output logic [7:0]           command_o,
    output logic [7:0]           prescale_o,
    output logic [ADDR_SIZE-1:0] slave_addr_rw_o,
    output logic                 empty_o,
    output logic                 full_o,
    output logic                 interrupt_o
);

    logic [7:0]           prescale_q, prescale_d;
    logic [7:0]           cmd_q, cmd_d;
    logic [ADDR_SIZE-1:0] slave_addr_q, slave_addr_d;
    logic [2:0]           irq_en_q, irq_en_d;
    logic [3:0]           sticky_q, sticky_d;
    logic                 interrupt_q, interrupt_d;

    logic access, wr_access, rd_access, addr_err;
    logic flush;
    logic tx_push, tx_full, tx_empty, tx_ovf, tx_under;
    logic rx_pop, rx_full, rx_empty, rx_ovf, rx_under;
    logic [DATA_SIZE-1:0] rx_head;
    logic [3:0] w1c;
    sticky_t    sticky_set;

    assign access    = psel_i & penable_i;
    assign addr_err  = (paddr_i > ADDR_IRQ_EN) || (pwrite_i && paddr_i == ADDR_RX_DATA);
    assign wr_access = access & pwrite_i & ~addr_err;
    assign rd_access = access & ~pwrite_i & ~addr_err;

    assign pready_o  = 1'b1;
    assign pslverr_o = access & addr_err;

    assign flush   = ~cmd_q[CMD_RESET_N];
    assign tx_push = wr_access && (paddr_i == ADDR_TX_DATA);
    assign rx_pop  = rd_access && (paddr_i == ADDR_RX_DATA);

    i2c_sync_fifo #(.DATA_SIZE(DATA_SIZE), .FIFO_DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk        (APB_clk_i),
        .rst_n      (reset_ni),
        .push_i     (tx_push),
        .pop_i      (r_fifo_en_i),
        .flush_i    (flush),
        .wdata_i    (DATA_SIZE'(pwdata_i)),
        .full_o     (tx_full),
        .empty_o    (tx_empty),
        .head_o     (data_o),
        .overflow_o (tx_ovf),
        .underflow_o(tx_under)
    );

    i2c_sync_fifo #(.DATA_SIZE(DATA_SIZE), .FIFO_DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk        (APB_clk_i),
        .rst_n      (reset_ni),
        .push_i     (w_fifo_en_i),
        .pop_i      (rx_pop),
        .flush_i    (flush),
        .wdata_i    (data_from_sda_i),
        .full_o     (rx_full),
        .empty_o    (rx_empty),
        .head_o     (rx_head),
        .overflow_o (rx_ovf),
        .underflow_o(rx_under)
    );

    always_comb begin
        prescale_d   = prescale_q;
        cmd_d        = cmd_q;
        slave_addr_d = slave_addr_q;
        irq_en_d     = irq_en_q;
        if (wr_access) begin
            case (paddr_i)
                ADDR_PRESCALE:   prescale_d   = pwdata_i;
                ADDR_CMD:        cmd_d        = pwdata_i & CMD_WRITE_MASK;
                ADDR_SLAVE_ADDR: slave_addr_d = ADDR_SIZE'(pwdata_i);
                ADDR_IRQ_EN:     irq_en_d     = pwdata_i[2:0];
                default:         ;
            endcase
        end
    end

    // A new error in the same cycle as its W1C wins, so no event is silently lost.
    always_comb begin
        sticky_set.tx_under = tx_under;
        sticky_set.rx_under = rx_under;
        sticky_set.rx_ovf   = rx_ovf;
        sticky_set.tx_ovf   = tx_ovf;
        w1c = (wr_access && paddr_i == ADDR_STATUS) ? pwdata_i[7:4] : 4'b0;
        sticky_d = (sticky_q & ~w1c) | sticky_set;
        if (flush) sticky_d = 4'b0;
    end

    always_comb begin
        interrupt_d = (irq_en_q[IRQ_ERR] & (|sticky_q))
                    | (irq_en_q[IRQ_TX_EMPTY] & tx_empty)
                    | (irq_en_q[IRQ_RX_NOT_EMPTY] & ~rx_empty);
    end

    always_comb begin
        prdata_o = 8'h00;
        if (rd_access) begin
            case (paddr_i)
                ADDR_PRESCALE:   prdata_o = prescale_q;
                ADDR_CMD:        prdata_o = cmd_q;
                ADDR_SLAVE_ADDR: prdata_o = 8'(slave_addr_q);
                ADDR_RX_DATA:    prdata_o = 8'(rx_head);
                ADDR_STATUS: begin
                    prdata_o[7:4]         = sticky_q;
                    prdata_o[STAT_TX_EMPTY] = tx_empty;
                    prdata_o[STAT_TX_FULL]  = tx_full;
                    prdata_o[STAT_RX_EMPTY] = rx_empty;
                    prdata_o[STAT_RX_FULL]  = rx_full;
                end
                ADDR_IRQ_EN:     prdata_o = {5'b0, irq_en_q};
                default:         prdata_o = 8'h00;
            endcase
        end
    end

    always_ff @(posedge APB_clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            prescale_q   <= PRESCALE_RESET;
            cmd_q        <= 8'h00;
            slave_addr_q <= '0;
            irq_en_q     <= 3'b0;
            sticky_q     <= 4'b0;
            interrupt_q  <= 1'b0;
        end else begin
            prescale_q   <= prescale_d;
            cmd_q        <= cmd_d;
            slave_addr_q <= slave_addr_d;
            irq_en_q     <= irq_en_d;
            sticky_q     <= sticky_d;
            interrupt_q  <= interrupt_d;
        end
    end

    assign command_o       = cmd_q;
    assign prescale_o      = prescale_q;
    assign slave_addr_rw_o = slave_addr_q;
    assign empty_o         = tx_empty;
    assign full_o          = rx_full;
    assign interrupt_o     = interrupt_q;

endmodule

// File: tb/tb_i2c_apb_regs.sv
// Directed self-checking bench for i2c_apb_regs: expected values are queued on a scoreboard
// as stimulus is applied and popped when the matching DUT output is sampled.
module tb_i2c_apb_regs;

    logic       APB_clk_i = 1'b0;
    logic       reset_ni;
    logic       psel_i, penable_i, pwrite_i;
    logic [7:0] paddr_i, pwdata_i, prdata_o;
    logic       pready_o, pslverr_o;
    logic       r_fifo_en_i, w_fifo_en_i;
    logic [7:0] data_o, data_from_sda_i;
    logic [7:0] command_o, prescale_o, slave_addr_rw_o;
    logic       empty_o, full_o, interrupt_o;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int fail_cnt  = 0;

    logic [7:0] exp_q[$];
    logic [7:0] tx_model[$];
    logic [7:0] rd_val;
    logic       rd_err;

    always #5 APB_clk_i = ~APB_clk_i;

    i2c_apb_regs dut (
        .APB_clk_i      (APB_clk_i),
        .reset_ni       (reset_ni),
        .psel_i         (psel_i),
        .penable_i      (penable_i),
        .pwrite_i       (pwrite_i),
        .paddr_i        (paddr_i),
        .pwdata_i       (pwdata_i),
        .prdata_o       (prdata_o),
        .pready_o       (pready_o),
        .pslverr_o      (pslverr_o),
        .r_fifo_en_i    (r_fifo_en_i),
        .data_o         (data_o),
        .w_fifo_en_i    (w_fifo_en_i),
        .data_from_sda_i(data_from_sda_i),
        .command_o      (command_o),
        .prescale_o     (prescale_o),
        .slave_addr_rw_o(slave_addr_rw_o),
        .empty_o        (empty_o),
        .full_o         (full_o),
        .interrupt_o    (interrupt_o)
    );

    task automatic expectValue(input logic [7:0] value);
        exp_q.push_back(value);
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed);
        logic [7:0] expected;
        total_cnt++;
        if (exp_q.size() == 0) begin
            fail_cnt++;
            $error("[TB] FAIL %s observed=0x%02h expected=<nothing queued>", tag, observed);
        end else begin
            expected = exp_q.pop_front();
            assert (observed === expected) begin
                pass_cnt = pass_cnt + 1;
            end else begin
                fail_cnt++;
                $error("[TB] FAIL %s observed=0x%02h expected=0x%02h", tag, observed, expected);
            end
        end
    endtask

    task automatic checkSignal(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        expectValue(expected);
        checkOutput(tag, observed);
    endtask

    // One full APB transfer; read data and error are sampled mid access phase, clear of the clock edge.
    task automatic applyStimulus(input logic write, input logic [7:0] addr, input logic [7:0] wdata,
                                 output logic [7:0] rdata, output logic err);
        @(posedge APB_clk_i); #1;
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = write; paddr_i = addr; pwdata_i = wdata;
        @(posedge APB_clk_i); #1;
        penable_i = 1'b1;
        #2;
        rdata = prdata_o;
        err   = pslverr_o;
        @(posedge APB_clk_i); #1;
        psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
    endtask

    task automatic regWrite(input logic [7:0] addr, input logic [7:0] data);
        logic [7:0] unused_rd;
        logic       unused_err;
        applyStimulus(1'b1, addr, data, unused_rd, unused_err);
    endtask

    task automatic regRead(input string tag, input logic [7:0] addr, input logic [7:0] expected);
        logic [7:0] rdata;
        logic       err;
        expectValue(expected);
        applyStimulus(1'b0, addr, 8'h00, rdata, err);
        checkOutput(tag, rdata);
    endtask

    task automatic corePop();
        r_fifo_en_i = 1'b1;
        @(posedge APB_clk_i); #1;
        r_fifo_en_i = 1'b0;
    endtask

    task automatic corePush(input logic [7:0] d);
        w_fifo_en_i = 1'b1; data_from_sda_i = d;
        @(posedge APB_clk_i); #1;
        w_fifo_en_i = 1'b0;
    endtask

    // RX_DATA read whose completing edge coincides with a core push.
    task automatic readWithPush(input string tag, input logic [7:0] push_data, input logic [7:0] expected);
        expectValue(expected);
        @(posedge APB_clk_i); #1;
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = 8'h04;
        @(posedge APB_clk_i); #1;
        penable_i = 1'b1; w_fifo_en_i = 1'b1; data_from_sda_i = push_data;
        #2;
        checkOutput(tag, prdata_o);
        @(posedge APB_clk_i); #1;
        psel_i = 1'b0; penable_i = 1'b0; w_fifo_en_i = 1'b0;
    endtask

    initial begin
        reset_ni = 1'b0;
        psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0; paddr_i = 8'h00; pwdata_i = 8'h00;
        r_fifo_en_i = 1'b0; w_fifo_en_i = 1'b0; data_from_sda_i = 8'h00;
        #23;
        checkSignal("rst_prdata", prdata_o, 8'h00);
        checkSignal("rst_pslverr", {7'b0, pslverr_o}, 8'h00);
        checkSignal("rst_pready", {7'b0, pready_o}, 8'h01);
        checkSignal("rst_command", command_o, 8'h00);
        checkSignal("rst_prescale", prescale_o, 8'h04);
        checkSignal("rst_slave_addr", slave_addr_rw_o, 8'h00);
        checkSignal("rst_data_o", data_o, 8'h00);
        checkSignal("rst_empty", {7'b0, empty_o}, 8'h01);
        checkSignal("rst_full", {7'b0, full_o}, 8'h00);
        checkSignal("rst_interrupt", {7'b0, interrupt_o}, 8'h00);
        @(posedge APB_clk_i); #1;
        reset_ni = 1'b1;

        $display("[TB] reset defaults and register read/write");
        regRead("rd_prescale_rst", 8'h00, 8'h04);
        regRead("rd_cmd_rst", 8'h01, 8'h00);
        regRead("rd_status_rst", 8'h05, 8'h05);
        regWrite(8'h01, 8'h80);
        checkSignal("command_after_wr", command_o, 8'h80);
        regWrite(8'h00, 8'h33);
        checkSignal("prescale_after_wr", prescale_o, 8'h33);
        regWrite(8'h02, 8'hA1);
        checkSignal("slave_addr_after_wr", slave_addr_rw_o, 8'hA1);
        regWrite(8'h01, 8'h8F);
        regRead("rd_cmd_reserved", 8'h01, 8'h80);

        $display("[TB] TX fill and drain");
        for (int i = 0; i < 16; i++) begin
            regWrite(8'h03, 8'(8'h10 + i));
            tx_model.push_back(8'(8'h10 + i));
        end
        regRead("status_tx_full", 8'h05, 8'h06);
        checkSignal("tx_head_first", data_o, 8'h10);
        checkSignal("tx_not_empty", {7'b0, empty_o}, 8'h00);
        regWrite(8'h03, 8'h99);
        regRead("status_tx_ovf", 8'h05, 8'h16);
        regWrite(8'h05, 8'h10);
        regRead("status_tx_ovf_w1c", 8'h05, 8'h06);
        for (int i = 0; i < 16; i++) begin
            checkSignal("tx_drain_head", data_o, tx_model.pop_front());
            corePop();
        end
        checkSignal("tx_drained_data", data_o, 8'h00);
        checkSignal("tx_drained_empty", {7'b0, empty_o}, 8'h01);
        corePop();
        regRead("status_tx_under", 8'h05, 8'h85);
        regWrite(8'h05, 8'h80);

        $display("[TB] RX push/pop with interrupt");
        regWrite(8'h06, 8'h01);
        checkSignal("irq_idle", {7'b0, interrupt_o}, 8'h00);
        corePush(8'hA5);
        checkSignal("irq_lag", {7'b0, interrupt_o}, 8'h00);
        @(posedge APB_clk_i); #1;
        checkSignal("irq_rise", {7'b0, interrupt_o}, 8'h01);
        regRead("rx_read_a5", 8'h04, 8'hA5);
        checkSignal("irq_hold_after_pop", {7'b0, interrupt_o}, 8'h01);
        @(posedge APB_clk_i); #1;
        checkSignal("irq_clear", {7'b0, interrupt_o}, 8'h00);
        regRead("rx_read_empty", 8'h04, 8'h00);
        regRead("status_rx_under", 8'h05, 8'h45);
        regWrite(8'h05, 8'h40);

        $display("[TB] simultaneous push/pop on full and empty RX");
        for (int i = 0; i < 16; i++) corePush(8'(8'h20 + i));
        checkSignal("rx_full", {7'b0, full_o}, 8'h01);
        regRead("status_rx_full", 8'h05, 8'h09);
        readWithPush("rx_full_pushpop", 8'hEE, 8'h20);
        checkSignal("rx_full_after", {7'b0, full_o}, 8'h00);
        regRead("status_rx_ovf", 8'h05, 8'h21);
        for (int i = 1; i < 16; i++) regRead("rx_drain", 8'h04, 8'(8'h20 + i));
        regRead("status_rx_count15", 8'h05, 8'h25);
        regWrite(8'h05, 8'h20);
        regRead("status_rx_ovf_w1c", 8'h05, 8'h05);
        readWithPush("rx_empty_pushpop", 8'h77, 8'h00);
        regRead("rx_read_77", 8'h04, 8'h77);
        regRead("status_rx_count1", 8'h05, 8'h45);

        $display("[TB] soft reset and error response");
        regWrite(8'h03, 8'h31);
        regWrite(8'h03, 8'h32);
        regWrite(8'h03, 8'h33);
        checkSignal("tx_3_entries", {7'b0, empty_o}, 8'h00);
        regWrite(8'h01, 8'h00);
        checkSignal("flush_not_yet", {7'b0, empty_o}, 8'h00);
        @(posedge APB_clk_i); #1;
        checkSignal("flush_empty", {7'b0, empty_o}, 8'h01);
        regRead("status_after_flush", 8'h05, 8'h05);
        checkSignal("prescale_kept", prescale_o, 8'h33);

        applyStimulus(1'b1, 8'h07, 8'hFF, rd_val, rd_err);
        checkSignal("err_wr_unmapped", {7'b0, rd_err}, 8'h01);
        applyStimulus(1'b0, 8'h07, 8'h00, rd_val, rd_err);
        checkSignal("err_rd_unmapped", {7'b0, rd_err}, 8'h01);
        checkSignal("err_rd_unmapped_data", rd_val, 8'h00);
        applyStimulus(1'b1, 8'h04, 8'h5A, rd_val, rd_err);
        checkSignal("err_wr_rx_data", {7'b0, rd_err}, 8'h01);
        applyStimulus(1'b0, 8'h00, 8'h00, rd_val, rd_err);
        checkSignal("no_err_prescale", {7'b0, rd_err}, 8'h00);
        checkSignal("err_prescale_kept", prescale_o, 8'h33);
        checkSignal("err_cmd_kept", command_o, 8'h00);
        checkSignal("err_slave_kept", slave_addr_rw_o, 8'hA1);
        regRead("err_irq_en_kept", 8'h06, 8'h01);

        $display("[TB] sticky error interrupt and W1C");
        regWrite(8'h01, 8'h80);
        regWrite(8'h06, 8'h04);
        checkSignal("irq_err_idle", {7'b0, interrupt_o}, 8'h00);
        corePop();
        regRead("rx_under_read", 8'h04, 8'h00);
        regRead("status_both_under", 8'h05, 8'hC5);
        checkSignal("irq_err_set", {7'b0, interrupt_o}, 8'h01);
        regWrite(8'h05, 8'hF0);
        regRead("status_w1c_all", 8'h05, 8'h05);
        checkSignal("irq_err_clear", {7'b0, interrupt_o}, 8'h00);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
